frame_unpacker: RTL and testbench
=================================

FRAME_UNPACKER -- requirements
Module: frame_unpacker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 2, bits per symbol.
REQ-002 SHALL have parameter DATA_DEPTH, default 16, symbols per frame word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, frame words buffered (power of two, >=2).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  single-cycle frame strobe from SPI receiver.
REQ-007 SHALL have port in_data  input  DATA_WIDTH*DATA_DEPTH  frame word, valid when in_valid high.
REQ-008 SHALL have port out_ready  input  1  consumer accepts symbol.
REQ-009 SHALL have port out_valid  output  1  out_data holds a symbol.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  current symbol.
REQ-011 SHALL have port out_last  output  1  current symbol is last of its frame.
REQ-012 SHALL have port busy  output  1  high in EMIT or FIFO non-empty.
REQ-013 SHALL have port overflow  output  1  one-cycle pulse when a frame is dropped.

Function
REQ-014 SHALL push in_data into the FIFO on clk edge when in_valid high and FIFO not full, or full with a pop in the same cycle.
REQ-015 SHALL drop the frame and pulse overflow the next cycle when in_valid high, FIFO full, no same-cycle pop; FIFO contents unchanged.
REQ-016 SHALL implement FSM states IDLE and EMIT; IDLE->EMIT when FIFO non-empty (pop into current-word register, symbol index=0).
REQ-017 SHALL emit symbol k as in_data[W*D-1-k*W -: W] (first-received bits first), k=0..DATA_DEPTH-1.
REQ-018 SHALL hold out_valid high in EMIT only; out_data/out_last stable while out_valid high and out_ready low.
REQ-019 SHALL advance symbol index on out_valid && out_ready; out_last high when index==DATA_DEPTH-1.
REQ-020 SHALL, on accepted last symbol, pop next word and stay in EMIT with index 0 if FIFO non-empty (zero bubble), else go IDLE.
REQ-021 SHALL give latency: in_valid in cycle N with FSM IDLE and FIFO empty -> out_valid high in cycle N+2.
REQ-022 SHALL drive out_data=0 and out_last=0 when out_valid low.
REQ-023 SHALL size FIFO count as $clog2(FIFO_DEPTH+1) bits, pointers wrap modulo FIFO_DEPTH.

Reset
REQ-024 SHALL on nrst low clear FIFO, pointers, count, index, current word, state=IDLE; out_valid, out_data, out_last, busy, overflow all 0.
REQ-025 SHALL discard any partially emitted frame when reset asserts mid-operation; no symbols emitted after release until a new in_valid.

Configuration
REQ-026 SHALL, with FRAME_UNPACKER_OVF_CNT_EN defined, add output overflow_count (8 bits) incrementing on each overflow pulse, saturating at 255, reset 0.
REQ-027 SHALL, without FRAME_UNPACKER_OVF_CNT_EN, omit overflow_count port and its logic entirely.

Structure
REQ-028 SHALL place FSM state enum (IDLE, EMIT) and default width constants in shared package spi_pkg.
REQ-029 SHALL implement buffer as sub-module frame_fifo (push, pop, full, empty, wdata, rdata).

Verification
REQ-030 Single frame 0xE4E4_E4E4, out_ready=1 -> out_valid at N+2, 16 symbols 3,2,1,0 repeating, out_last on 16th only.
REQ-031 out_ready toggled 1/0 each cycle on one frame -> 16 symbols, data held on stalls, 31 cycles to drain.
REQ-032 Two frames 0xFFFF_FFFF then 0x0000_0000 back-to-back, out_ready=1 -> 32 consecutive valid cycles, no bubble at frame boundary.
REQ-033 out_ready=0, three frames 1 cycle apart -> first loaded, FIFO fills with second and third, fourth frame -> overflow pulse, overflow_count=1 when enabled.
REQ-034 Push while full and last symbol accepted same cycle -> frame accepted, no overflow.
REQ-035 nrst low after symbol 5 -> outputs 0 next cycle, busy 0, no emission until new in_valid.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI receive path (frame unpacker and its FIFO).
package spi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpack_state_t;

    localparam int DEFAULT_DATA_WIDTH = 2;
    localparam int DEFAULT_DATA_DEPTH = 16;
    localparam int DEFAULT_FIFO_DEPTH = 2;

endpackage

// File: rtl/frame_fifo.sv
// Small synchronous FIFO of whole frame words; rdata always shows the oldest entry.
// A push while full is taken only when a pop happens in the same cycle.
module frame_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH * DEFAULT_DATA_DEPTH,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_unpacker.sv
// Buffers frame words from the SPI receiver and replays them one symbol at a time, MSB symbol first.
// Define FRAME_UNPACKER_OVF_CNT_EN to add a saturating 8-bit overflow_count output.
module frame_unpacker
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DATA_DEPTH = DEFAULT_DATA_DEPTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] in_data,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic                             busy,
    output logic                             overflow
`ifdef FRAME_UNPACKER_OVF_CNT_EN
    ,
    output logic [7:0]                       overflow_count
`endif
);

    localparam int FW    = DATA_WIDTH * DATA_DEPTH;
    localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_DEPTH - 1);

    unpack_state_t    state, state_nxt;
    logic [FW-1:0]    cur_word, cur_word_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             pop;
    logic             full;
    logic             empty;
    logic [FW-1:0]    rdata;

    frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_data),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    // cur_word is shifted left on every accept so the current symbol is always its top slice
    always_comb begin
        state_nxt    = state;
        cur_word_nxt = cur_word;
        idx_nxt      = idx;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    cur_word_nxt = rdata;
                    idx_nxt      = '0;
                    state_nxt    = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        if (!empty) begin
                            pop          = 1'b1;
                            cur_word_nxt = rdata;
                        end else begin
                            cur_word_nxt = '0;
                            state_nxt    = IDLE;
                        end
                    end else begin
                        idx_nxt      = idx + 1'b1;
                        cur_word_nxt = cur_word << DATA_WIDTH;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cur_word <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_word <= cur_word_nxt;
            idx      <= idx_nxt;
            overflow <= in_valid && full && !pop;
        end
    end

    assign out_valid = (state == EMIT);
    assign out_data  = out_valid ? cur_word[FW-1 -: DATA_WIDTH] : '0;
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign busy      = (state == EMIT) || !empty;

`ifdef FRAME_UNPACKER_OVF_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overflow_count <= '0;
        end else if (overflow && (overflow_count != 8'hFF)) begin
            overflow_count <= overflow_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_unpacker.sv
// Directed self-checking bench for frame_unpacker at default parameters (2-bit symbols, 16 per frame).
module tb_frame_unpacker;

    localparam int W  = 2;
    localparam int D  = 16;
    localparam int FW = W * D;

    logic          clk;
    logic          nrst;
    logic          in_valid;
    logic [FW-1:0] in_data;
    logic          out_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          overflow;
`ifdef FRAME_UNPACKER_OVF_CNT_EN
    logic [7:0]    overflow_count;
`endif

    int assertCount = 0;
    int failCount   = 0;

    frame_unpacker dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow)
`ifdef FRAME_UNPACKER_OVF_CNT_EN
        ,
        .overflow_count (overflow_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [FW-1:0] data, input logic ready);
        in_valid  = v;
        in_data   = data;
        out_ready = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sym(input logic [FW-1:0] word, input int k);
        logic [FW-1:0] s;
        s = word >> (FW - W - k * W);
        return {30'd0, s[W-1:0]};
    endfunction

    // Consume one whole frame with out_ready held high, checking every symbol
    task automatic expectFrame(input logic [FW-1:0] word, input string tag);
        int waitCnt = 0;
        out_ready = 1'b1;
        while (!out_valid && waitCnt < 10) begin
            tick();
            waitCnt++;
        end
        checkOutput({tag, "_start"}, 32'(out_valid), 32'd1);
        for (int k = 0; k < D; k++) begin
            checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_data"}, 32'(out_data), sym(word, k));
            checkOutput({tag, "_last"}, 32'(out_last), 32'(k == D - 1));
            tick();
        end
    endtask

    initial begin
        int k;
        int c;
        int cyc;
        int seen;

        applyStimulus(1'b0, '0, 1'b0);
        nrst = 1'b0;
        tick();
        tick();
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_last", 32'(out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
`ifdef FRAME_UNPACKER_OVF_CNT_EN
        checkOutput("rst_ovf_cnt", 32'(overflow_count), 32'd0);
`endif
        nrst = 1'b1;
        tick();

        // Single frame: latency of two cycles, then 3,2,1,0 repeating
        applyStimulus(1'b1, 32'hE4E4_E4E4, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("lat_n1_valid", 32'(out_valid), 32'd0);
        checkOutput("lat_n1_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("lat_n2_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < D; i++) begin
            checkOutput("single_data", 32'(out_data), 32'(3 - (i % 4)));
            checkOutput("single_last", 32'(out_last), 32'(i == D - 1));
            tick();
        end
        checkOutput("single_done_valid", 32'(out_valid), 32'd0);
        checkOutput("single_done_busy", 32'(busy), 32'd0);

        // out_ready alternating: symbols held across stalls, 31 valid cycles
        applyStimulus(1'b1, 32'h0123_4567, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        k = 0;
        c = 0;
        cyc = 0;
        while (k < D && cyc < 80) begin
            if (out_valid) begin
                out_ready = (c % 2 == 0);
                checkOutput("stall_data", 32'(out_data), sym(32'h0123_4567, k));
                if (out_ready) k++;
                c++;
            end
            tick();
            cyc++;
        end
        checkOutput("stall_symbols", 32'(k), 32'd16);
        checkOutput("stall_cycles", 32'(c), 32'd31);
        checkOutput("stall_done_valid", 32'(out_valid), 32'd0);

        // Back-to-back frames: 32 valid cycles with no bubble
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h0000_0000, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("b2b_start", 32'(out_valid), 32'd1);
        for (int i = 0; i < 2 * D; i++) begin
            checkOutput("b2b_valid", 32'(out_valid), 32'd1);
            checkOutput("b2b_data", 32'(out_data), (i < D) ? 32'd3 : 32'd0);
            checkOutput("b2b_last", 32'(out_last), 32'(i == D - 1 || i == 2 * D - 1));
            tick();
        end
        checkOutput("b2b_done_valid", 32'(out_valid), 32'd0);

        // Overflow: consumer stalled, fourth frame dropped
        applyStimulus(1'b1, 32'h1111_1111, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h2222_2222, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h3333_3333, 1'b0);
        tick();
        checkOutput("ovf_pre", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 32'hDDDD_DDDD, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("ovf_pulse", 32'(overflow), 32'd1);
        tick();
        checkOutput("ovf_clear", 32'(overflow), 32'd0);
`ifdef FRAME_UNPACKER_OVF_CNT_EN
        checkOutput("ovf_cnt_1", 32'(overflow_count), 32'd1);
`endif
        checkOutput("ovf_hold_data", 32'(out_data), sym(32'h1111_1111, 0));
        expectFrame(32'h1111_1111, "ovf_a");
        expectFrame(32'h2222_2222, "ovf_b");
        expectFrame(32'h3333_3333, "ovf_c");
        checkOutput("ovf_done_valid", 32'(out_valid), 32'd0);
        checkOutput("ovf_done_busy", 32'(busy), 32'd0);

        // Push while full accepted because the last symbol pops in the same cycle
        applyStimulus(1'b1, 32'h4567_89AB, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hCDEF_0123, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h5A5A_A5A5, 1'b0);
        tick();
        for (int i = 0; i < D; i++) begin
            applyStimulus(i == D - 1, 32'h9876_5432, 1'b1);
            checkOutput("fullpop_data", 32'(out_data), sym(32'h4567_89AB, i));
            checkOutput("fullpop_last", 32'(out_last), 32'(i == D - 1));
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("fullpop_no_ovf", 32'(overflow), 32'd0);
        expectFrame(32'hCDEF_0123, "fullpop_b");
        expectFrame(32'h5A5A_A5A5, "fullpop_c");
        expectFrame(32'h9876_5432, "fullpop_d");
        checkOutput("fullpop_done_valid", 32'(out_valid), 32'd0);
`ifdef FRAME_UNPACKER_OVF_CNT_EN
        checkOutput("fullpop_ovf_cnt", 32'(overflow_count), 32'd1);
`endif

        // Reset mid-frame discards the current word and the buffered one
        applyStimulus(1'b1, 32'hE4E4_E4E4, 1'b1);
        tick();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        checkOutput("midrst_pre_data", 32'(out_data), 32'd1);
        nrst = 1'b0;
        tick();
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_data", 32'(out_data), 32'd0);
        checkOutput("midrst_last", 32'(out_last), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        nrst = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid || busy) seen++;
        end
        checkOutput("midrst_silent", 32'(seen), 32'd0);
        applyStimulus(1'b1, 32'hB1B1_B1B1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        expectFrame(32'hB1B1_B1B1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
